// File: rtl/scan_ctrl2.sv
// scan_ctrl2 - two-digit time-multiplexed 7-segment scan controller.
//
// Cycles BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 forever. Each show state lasts
// DIV clocks and each blank (dead-time) state lasts BLANK clocks. Both digit
// values are snapshotted once per frame so a digit never changes mid-frame.
//
// Parameters:
//   DIV        dwell length of each digit in clk cycles (>= 1)
//   BLANK      dead-time length before each digit in clk cycles (>= 1)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   EN         display enable, active high (registered before use)
//   in0, in1   ones / tens digit values (BCD)
//   lz_blank   1 = suppress the tens digit when its snapshot is 0
//   sel        shared digit-mux select (0 = ones, 1 = tens)
//   out        value presented to the segment decoder (4'b1110 = "E" when disabled)
//   an         active-low digit enables, an[0] = ones, an[1] = tens
//   frame_tick one-cycle pulse on the last cycle of each frame

`timescale 1ns/1ps

module scan_ctrl2 #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       lz_blank,
  output logic       sel,
  output logic [3:0] out,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int MAXL = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [3:0]    ERR_CODE   = 4'b1110;

  typedef enum logic [1:0] {
    S_BLANK0 = 2'd0,
    S_SHOW0  = 2'd1,
    S_BLANK1 = 2'd2,
    S_SHOW1  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          at_end;
  logic [3:0]    snap0;
  logic [3:0]    snap1;
  logic          en_q;
  logic          lz_q;

  // Terminal count for the current state: show states dwell DIV cycles,
  // blank states dwell BLANK cycles.
  always_comb begin
    last = BLANK_LAST;
    if (state == S_SHOW0 || state == S_SHOW1)
      last = SHOW_LAST;
  end

  assign at_end = (cnt == last);

  // Scan FSM, dwell counter, per-frame snapshot and input registers.
  // lz_blank is registered alongside EN so every output is decoded purely
  // from flops and no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BLANK0;
      cnt   <= '0;
      snap0 <= 4'd0;
      snap1 <= 4'd0;
      en_q  <= 1'b0;
      lz_q  <= 1'b0;
    end else begin
      en_q <= EN;
      lz_q <= lz_blank;

      // Snapshot on the first cycle of the frame; visible from cycle 1.
      if (state == S_BLANK0 && cnt == '0) begin
        snap0 <= in0;
        snap1 <= in1;
      end

      if (at_end) begin
        cnt <= '0;
        case (state)
          S_BLANK0: state <= S_SHOW0;
          S_SHOW0:  state <= S_BLANK1;
          S_BLANK1: state <= S_SHOW1;
          default:  state <= S_BLANK0;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Output decode from registered state only. sel flips on entry to a
  // blank state so out settles during the dead time before an turns on.
  always_comb begin
    sel        = 1'b0;
    an         = 2'b11;
    frame_tick = 1'b0;
    case (state)
      S_BLANK0: begin
        sel = 1'b0;
        an  = 2'b11;
      end
      S_SHOW0: begin
        sel = 1'b0;
        an  = 2'b10;
      end
      S_BLANK1: begin
        sel = 1'b1;
        an  = 2'b11;
      end
      default: begin
        sel        = 1'b1;
        an         = (en_q && lz_q && snap1 == 4'd0) ? 2'b11 : 2'b01;
        frame_tick = (cnt == SHOW_LAST);
      end
    endcase
    out = en_q ? (sel ? snap1 : snap0) : ERR_CODE;
  end

endmodule
